// File: rtl/arb_pkt2.sv
// Two-input packet-granular round-robin arbiter onto one valid/ready link.
// The grant is held for a whole packet; a registered output stage absorbs backpressure.
//
// state | meaning
// IDLE  | no grant; pick the next port from the requesters and the round-robin pointer
// XFER  | grant held by arb_id; forward beats until last or the beat limit
module arb_pkt2 #(
    parameter int DW     = 32,
    parameter int MAXLEN = 16,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_vld,
    input  logic [DW-1:0] in0_dat,
    input  logic          in0_last,
    output logic          in0_rdy,
    input  logic          in1_vld,
    input  logic [DW-1:0] in1_dat,
    input  logic          in1_last,
    output logic          in1_rdy,
    output logic          out_vld,
    output logic [DW-1:0] out_dat,
    output logic          out_last,
    output logic          out_id,
    input  logic          out_rdy,
    output logic          arb_id,
    output logic          len_err
);

    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAXLEN - 1);

    state_t        state, state_nxt;
    logic          arb_id_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          slot_free;
    logic          acc;
    logic          beat_last;
    logic          trunc;
    logic          sel_vld;
    logic          sel_last;
    logic [DW-1:0] sel_dat;

    assign slot_free = ~out_vld | out_rdy;
    assign sel_vld   = arb_id ? in1_vld  : in0_vld;
    assign sel_last  = arb_id ? in1_last : in0_last;
    assign sel_dat   = arb_id ? in1_dat  : in0_dat;

    always_comb begin
        state_nxt  = state;
        arb_id_nxt = arb_id;
        cnt_nxt    = cnt;
        in0_rdy    = 1'b0;
        in1_rdy    = 1'b0;
        acc        = 1'b0;
        beat_last  = 1'b0;
        trunc      = 1'b0;
        case (state)
            IDLE: begin
                if (in0_vld | in1_vld) begin
                    // the port not granted last wins a tie
                    arb_id_nxt = arb_id ? ~in0_vld : in1_vld;
                    cnt_nxt    = '0;
                    state_nxt  = XFER;
                end
            end
            XFER: begin
                in0_rdy = slot_free & ~arb_id;
                in1_rdy = slot_free & arb_id;
                acc     = slot_free & sel_vld;
                if (acc) begin
                    beat_last = sel_last | (cnt == CNT_MAX);
                    trunc     = (cnt == CNT_MAX) & ~sel_last;
                    cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                    if (beat_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            arb_id <= 1'b1;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            arb_id <= arb_id_nxt;
            cnt <= cnt_nxt;
        end
    end

    // output register drains on its own, whatever the FSM is doing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
            out_id   <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            len_err <= trunc;
            if (acc) begin
                out_vld  <= 1'b1;
                out_dat  <= sel_dat;
                out_last <= beat_last;
                out_id   <= arb_id;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule
